// File: rtl/seg7_scan_if.sv
// Write/display bundle for seg7_scan_ctrl: staging handshake plus the multiplexed digit outputs.
interface seg7_scan_if;
    logic        wr_valid;
    logic [15:0] wr_data;
    logic        wr_ready;
    logic [3:0]  bcd;
    logic [3:0]  dig_en;
    logic        bad_digit;

    modport master (
        output wr_valid, wr_data,
        input  wr_ready, bcd, dig_en, bad_digit
    );

    modport slave (
        input  wr_valid, wr_data,
        output wr_ready, bcd, dig_en, bad_digit
    );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with frame-aligned double buffering.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_scan_ctrl #(
    parameter int PRESCALE = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    seg7_scan_if.slave  bus
);

    localparam logic [15:0] CNT_LAST = 16'(PRESCALE - 1);

    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic [15:0] pend_q, pend_d;
    logic [15:0] disp_q, disp_d;
    logic        pend_full_q, pend_full_d;
    logic        bad_q, bad_d;
    logic [3:0]  bcd_q, bcd_d;
    logic [3:0]  dig_en_q, dig_en_d;

    logic        tick_s;
    logic        frame_end_s;
    logic        wr_fire_s;
    logic [3:0]  nib_s;
    logic        blank_s;

    function automatic logic has_bad_nibble(input logic [15:0] w);
        logic r;
        r = 1'b0;
        for (int k = 0; k < 4; k++) begin
            r = r | (w[4*k +: 4] > 4'd9);
        end
        return r;
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] i);
        logic [3:0] r;
        case (i)
            2'd0:    r = 4'b0001;
            2'd1:    r = 4'b0010;
            2'd2:    r = 4'b0100;
            2'd3:    r = 4'b1000;
            default: r = 4'b0000;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] select_nibble(input logic [15:0] w, input logic [1:0] i);
        logic [3:0] r;
        case (i)
            2'd0:    r = w[3:0];
            2'd1:    r = w[7:4];
            2'd2:    r = w[11:8];
            2'd3:    r = w[15:12];
            default: r = 4'h0;
        endcase
        return r;
    endfunction

`ifdef SEG7_LZB_EN
    // Digit k>0 is a leading zero when it and every higher nibble are zero.
    function automatic logic leading_zero(input logic [15:0] w, input logic [1:0] i);
        logic r;
        case (i)
            2'd3:    r = (w[15:12] == 4'd0);
            2'd2:    r = (w[15:8] == 8'd0);
            2'd1:    r = (w[15:4] == 12'd0);
            default: r = 1'b0;
        endcase
        return r;
    endfunction
`endif

    assign tick_s      = (cnt_q == CNT_LAST);
    assign frame_end_s = tick_s && (idx_q == 2'd3);
    assign wr_fire_s   = bus.wr_valid && !pend_full_q;
    assign nib_s       = select_nibble(disp_q, idx_q);

`ifdef SEG7_LZB_EN
    assign blank_s = (nib_s > 4'd9) || leading_zero(disp_q, idx_q);
`else
    assign blank_s = (nib_s > 4'd9);
`endif

    // Next-state: prescaler, digit index, staging/display buffers and scan outputs.
    always_comb begin
        cnt_d       = tick_s ? 16'd0 : cnt_q + 16'd1;
        idx_d       = tick_s ? idx_q + 2'd1 : idx_q;
        pend_d      = pend_q;
        disp_d      = disp_q;
        pend_full_d = pend_full_q;
        bad_d       = bad_q;
        bcd_d       = nib_s;
        dig_en_d    = blank_s ? 4'b0000 : onehot(idx_q);

        // Swap only at frame boundary so a frame never mixes two words.
        if (frame_end_s && pend_full_q) begin
            disp_d      = pend_q;
            pend_full_d = 1'b0;
        end else begin
            disp_d      = disp_q;
        end

        // wr_fire needs pend empty, so it can never collide with the swap above.
        if (wr_fire_s) begin
            pend_d      = bus.wr_data;
            pend_full_d = 1'b1;
            bad_d       = bad_q | has_bad_nibble(bus.wr_data);
        end else begin
            pend_d      = pend_q;
        end
    end

    // State register with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= 16'd0;
            idx_q       <= 2'd0;
            pend_q      <= 16'h0000;
            disp_q      <= 16'h0000;
            pend_full_q <= 1'b0;
            bad_q       <= 1'b0;
            bcd_q       <= 4'h0;
            dig_en_q    <= 4'b0000;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            pend_q      <= pend_d;
            disp_q      <= disp_d;
            pend_full_q <= pend_full_d;
            bad_q       <= bad_d;
            bcd_q       <= bcd_d;
            dig_en_q    <= dig_en_d;
        end
    end

    assign bus.wr_ready  = !pend_full_q;
    assign bus.bcd       = bcd_q;
    assign bus.dig_en    = dig_en_q;
    assign bus.bad_digit = bad_q;

endmodule
